// File: rtl/uart_tx_frame_if.sv
// Handshake bundle between a byte source and the UART transmit framer.
// The master drives the byte and start request; the slave returns line, busy and done.
interface uart_tx_frame_if;
  logic [7:0] DataToTransmit;
  logic       Transmit;
  logic       SerialOutputTx;
  logic       Busy;
  logic       TxDone;

  modport master (
    output DataToTransmit,
    output Transmit,
    input  SerialOutputTx,
    input  Busy,
    input  TxDone
  );

  modport slave (
    input  DataToTransmit,
    input  Transmit,
    output SerialOutputTx,
    output Busy,
    output TxDone
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional parity, stop bit.
// Parity bit is built only when UART_TX_PARITY_EN is defined (8O1/8E1), otherwise 8N1.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | line high, waiting for Transmit
// S_START  | start bit (line low) for one bit time
// S_DATA   | data bits, LSB first, idx_q selects 0..7
// S_PARITY | parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit (line high); last clock returns to idle
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_ODD   = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_frame_if.slave tx
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          line_q, line_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`else
  localparam bit unused_parity_odd = PARITY_ODD;
`endif

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx.Transmit) begin
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = tx.DataToTransmit;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx.DataToTransmit) ^ PARITY_ODD;
`endif
        end
      end
      S_START: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          // index 7 is the last data bit; never wrap into a ninth
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered line moves on the same edge.
  always_comb begin
    line_d = 1'b1;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
        done_d = (state_q == S_STOP);
      end
      S_START: line_d = 1'b0;
      S_DATA:  line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_d = par_d;
`endif
      S_STOP:  line_d = 1'b1;
      default: begin
        line_d = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign tx.SerialOutputTx = line_q;
  assign tx.Busy           = busy_q;
  assign tx.TxDone         = done_q;

endmodule
